// File: rtl/acorn128_pkg.sv
// Shared types and fixed phase lengths for the ACORN-128 control sequencer.
package acorn128_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    AD      = 3'd2,
    AD_PAD  = 3'd3,
    ENC     = 3'd4,
    ENC_PAD = 3'd5,
    FIN     = 3'd6
  } phase_e;

  localparam int          CNT_W        = 11;
  localparam logic [10:0] INIT_STEPS   = 11'd1792;
  localparam logic [10:0] PAD_STEPS    = 11'd256;
  localparam logic [10:0] PAD_CA_STEPS = 11'd128;
  localparam logic [10:0] FIN_STEPS    = 11'd768;
  localparam logic [10:0] TAG_BITS     = 11'd128;

  // Counter value on the final step of each fixed-length phase.
  function automatic logic [CNT_W-1:0] last_step(phase_e s);
    case (s)
      INIT:            last_step = INIT_STEPS - 11'd1;
      AD_PAD, ENC_PAD: last_step = PAD_STEPS - 11'd1;
      FIN:             last_step = FIN_STEPS - 11'd1;
      default:         last_step = '1;
    endcase
  endfunction

endpackage

// File: rtl/acorn128_ctrl_if.sv
// Control/stream bundle between the ACORN-128 sequencer and its environment.
// Status ports exist only when ACORN_CTRL_STATUS_EN is defined.
interface acorn128_ctrl_if;
  logic         start;
  logic [127:0] key;
  logic [127:0] iv;
  logic         ad_empty, pt_empty;
  logic         ad_bit, ad_valid, ad_last, ad_ready;
  logic         pt_bit, pt_valid, pt_last, pt_ready;
  logic         ks_bit;
  logic         step_en, ca, cb, mbit;
  logic         ct_bit, ct_valid;
  logic         tag_bit, tag_valid;
  logic         busy, done;
`ifdef ACORN_CTRL_STATUS_EN
  logic [2:0]   phase;
  logic [31:0]  total_steps;
`endif

  modport master (
    input  start, key, iv, ad_empty, pt_empty, ad_bit, ad_valid, ad_last,
           pt_bit, pt_valid, pt_last, ks_bit,
`ifdef ACORN_CTRL_STATUS_EN
    output phase, total_steps,
`endif
    output ad_ready, pt_ready, step_en, ca, cb, mbit, ct_bit, ct_valid,
           tag_bit, tag_valid, busy, done
  );

  modport slave (
    output start, key, iv, ad_empty, pt_empty, ad_bit, ad_valid, ad_last,
           pt_bit, pt_valid, pt_last, ks_bit,
`ifdef ACORN_CTRL_STATUS_EN
    input  phase, total_steps,
`endif
    input  ad_ready, pt_ready, step_en, ca, cb, mbit, ct_bit, ct_valid,
           tag_bit, tag_valid, busy, done
  );
endinterface

// File: rtl/acorn128_step_cnt.sv
// Per-phase step counter; clear has priority so a phase always starts at 0.
module acorn128_step_cnt import acorn128_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == limit);
endmodule

// File: rtl/acorn128_ctrl.sv
// Bit-serial phase sequencer driving the ACORN-128 state-update datapath.
// Optional status outputs (phase, total_steps) under ACORN_CTRL_STATUS_EN.
module acorn128_ctrl import acorn128_pkg::*; (
  input  logic           clk,
  input  logic           rst,
  acorn128_ctrl_if.master bus
);
  phase_e           state, state_nx;
  logic [127:0]     key_q, iv_q;
  logic             ad_empty_q, pt_empty_q;
  logic [CNT_W-1:0] n;
  logic             tc;
  logic             step_en, ca, cb, mbit, ad_ready, pt_ready;
  logic             ct_bit_q, ct_valid_q, tag_bit_q, tag_valid_q, done_q;
  logic             ct_fire, tag_fire;

  acorn128_step_cnt u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_nx != state),
    .en    (step_en),
    .limit (last_step(state)),
    .cnt   (n),
    .tc    (tc)
  );

  always_comb begin
    state_nx = state;
    step_en  = 1'b0;
    ca       = 1'b0;
    cb       = 1'b0;
    mbit     = 1'b0;
    ad_ready = 1'b0;
    pt_ready = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nx = INIT;
      INIT: begin
        step_en = 1'b1;
        ca      = 1'b1;
        cb      = 1'b1;
        // key, then iv, then a flipped key[0], then the key repeated
        if (n < 11'd128)       mbit = key_q[n[6:0]];
        else if (n < 11'd256)  mbit = iv_q[n[6:0]];
        else if (n == 11'd256) mbit = ~key_q[0];
        else                   mbit = key_q[n[6:0]];
        if (tc) state_nx = ad_empty_q ? AD_PAD : AD;
      end
      AD: begin
        ad_ready = 1'b1;
        step_en  = bus.ad_valid;
        mbit     = bus.ad_bit;
        ca       = 1'b1;
        cb       = 1'b1;
        if (bus.ad_valid && bus.ad_last) state_nx = AD_PAD;
      end
      AD_PAD: begin
        step_en = 1'b1;
        mbit    = (n == '0);
        ca      = (n < PAD_CA_STEPS);
        cb      = 1'b1;
        if (tc) state_nx = pt_empty_q ? ENC_PAD : ENC;
      end
      ENC: begin
        pt_ready = 1'b1;
        step_en  = bus.pt_valid;
        mbit     = bus.pt_bit;
        ca       = 1'b1;
        if (bus.pt_valid && bus.pt_last) state_nx = ENC_PAD;
      end
      ENC_PAD: begin
        step_en = 1'b1;
        mbit    = (n == '0);
        ca      = (n < PAD_CA_STEPS);
        if (tc) state_nx = FIN;
      end
      FIN: begin
        step_en = 1'b1;
        ca      = 1'b1;
        cb      = 1'b1;
        if (tc) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ct_fire  = (state == ENC) && bus.pt_valid;
  assign tag_fire = (state == FIN) && (n >= FIN_STEPS - TAG_BITS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      key_q       <= '0;
      iv_q        <= '0;
      ad_empty_q  <= 1'b0;
      pt_empty_q  <= 1'b0;
      ct_bit_q    <= 1'b0;
      ct_valid_q  <= 1'b0;
      tag_bit_q   <= 1'b0;
      tag_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        key_q      <= bus.key;
        iv_q       <= bus.iv;
        ad_empty_q <= bus.ad_empty;
        pt_empty_q <= bus.pt_empty;
      end
      ct_valid_q  <= ct_fire;
      ct_bit_q    <= ct_fire & (bus.pt_bit ^ bus.ks_bit);
      tag_valid_q <= tag_fire;
      tag_bit_q   <= tag_fire & bus.ks_bit;
      done_q      <= (state == FIN) && tc;
    end
  end

  assign bus.step_en   = step_en;
  assign bus.ca        = ca;
  assign bus.cb        = cb;
  assign bus.mbit      = mbit;
  assign bus.ad_ready  = ad_ready;
  assign bus.pt_ready  = pt_ready;
  assign bus.ct_bit    = ct_bit_q;
  assign bus.ct_valid  = ct_valid_q;
  assign bus.tag_bit   = tag_bit_q;
  assign bus.tag_valid = tag_valid_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state != IDLE);

`ifdef ACORN_CTRL_STATUS_EN
  logic [31:0] total_q;

  // Saturating step count since the last accepted start.
  always_ff @(posedge clk) begin
    if (rst)                              total_q <= '0;
    else if (state == IDLE && bus.start)  total_q <= '0;
    else if (step_en && total_q != '1)    total_q <= total_q + 32'd1;
  end

  assign bus.phase       = state;
  assign bus.total_steps = total_q;
`endif
endmodule

// File: tb/tb_acorn128_ctrl.sv
// Scenario bench for acorn128_ctrl with ct/tag scoreboards.
module tb_acorn128_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acorn128_ctrl_if bus();
  acorn128_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  bit exp_q[$];

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.key = '0; bus.iv = '0; bus.ad_empty = 0; bus.pt_empty = 0;
    bus.ad_bit = 0; bus.ad_valid = 0; bus.ad_last = 0;
    bus.pt_bit = 0; bus.pt_valid = 0; bus.pt_last = 0; bus.ks_bit = 0;
  endtask

  function automatic logic [11:0] outs();
    return {bus.busy, bus.step_en, bus.ca, bus.cb, bus.mbit, bus.ct_valid, bus.ct_bit,
            bus.tag_valid, bus.tag_bit, bus.done, bus.ad_ready, bus.pt_ready};
  endfunction

  // Start in the current cycle; afterwards scramble the sampled inputs to prove latching.
  task automatic start_op(input logic [127:0] k, input logic [127:0] v, input logic ade, input logic pte);
    bus.start = 1; bus.key = k; bus.iv = v; bus.ad_empty = ade; bus.pt_empty = pte;
    next_cyc();
    bus.start = 0;
    bus.key = {$urandom, $urandom, $urandom, $urandom};
    bus.iv  = {$urandom, $urandom, $urandom, $urandom};
    bus.ad_empty = ~ade; bus.pt_empty = ~pte;
  endtask

  // Runs until done; FIN begins at relative cycle fin_j. Tag bits are scoreboarded.
  task automatic run_to_done(input int fin_j, input bit poke_start, input string nm, output int steps);
    int tags = 0, dones = 0, done_j = -1;
    bit ctl_bad = 0;
    exp_q.delete();
    steps = 0;
    for (int j = 0; j < fin_j + 800; j++) begin
      if (bus.tag_valid) begin
        tags++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL %s tag_extra: tag_valid=1 at j=%0d, required no strobe", nm, j);
        end else begin
          bit e;
          e = exp_q.pop_front();
          if (bus.tag_bit !== e) begin
            fails++;
            $display("FAIL %s tag_bit: got %0b at j=%0d, required %0b", nm, bus.tag_bit, j, e);
          end
        end
      end
      if (bus.done) begin dones++; done_j = j; end
      if (done_j >= 0 && j == done_j + 3) break;
      bus.ks_bit = 1'($urandom);
      bus.start  = poke_start && (j == fin_j + 100);
      bus.key    = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (bus.step_en) steps++;
      if (j >= fin_j && j < fin_j + 768 &&
          !(bus.step_en === 1 && bus.ca === 1 && bus.cb === 1 && bus.mbit === 0)) ctl_bad = 1;
      if (j >= fin_j + 640 && j < fin_j + 768) exp_q.push_back(bus.ks_bit);
      next_cyc();
    end
    bus.start = 0;
    tests++; if (done_j !== fin_j + 768) begin fails++; $display("FAIL %s done_time: got j=%0d, required j=%0d", nm, done_j, fin_j + 768); end
    tests++; if (dones !== 1) begin fails++; $display("FAIL %s done_count: got %0d, required 1", nm, dones); end
    tests++; if (tags !== 128) begin fails++; $display("FAIL %s tag_count: got %0d, required 128", nm, tags); end
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL %s tag_left: got %0d pending, required 0", nm, exp_q.size()); end
    tests++; if (ctl_bad !== 0) begin fails++; $display("FAIL %s fin_ctl: got bad=%0b, required 0", nm, ctl_bad); end
    tests++; if (bus.busy !== 0) begin fails++; $display("FAIL %s busy_after: got %0b, required 0", nm, bus.busy); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    next_cyc();
    next_cyc();
    tests++;
    if (outs() !== 12'h0) begin fails++; $display("FAIL reset_outs: got %h, required 000", outs()); end
    rst = 0;
  endtask

  task automatic test_empty_run();
    int steps;
    start_op('0, '0, 1, 1);
    run_to_done(2304, 0, "empty", steps);
    tests++;
    if (steps !== 3072) begin fails++; $display("FAIL empty step_count: got %0d, required 3072", steps); end
`ifdef ACORN_CTRL_STATUS_EN
    tests++;
    if (bus.total_steps !== 32'd3072) begin fails++; $display("FAIL empty total_steps: got %0d, required 3072", bus.total_steps); end
`endif
  endtask

  task automatic test_init();
    bit bad = 0;
    start_op(128'h1, '0, 0, 0);
    for (int c = 1; c <= 1792; c++) begin
      int n;
      n = c - 1;
      bus.ks_bit = 1'($urandom);
      #1;
      if (!(bus.step_en === 1 && bus.ca === 1 && bus.cb === 1 && bus.ad_ready === 0)) bad = 1;
      if (n == 0)   begin tests++; if (bus.mbit !== 1) begin fails++; $display("FAIL init_mbit0: got %0b, required 1", bus.mbit); end end
      if (n == 128) begin tests++; if (bus.mbit !== 0) begin fails++; $display("FAIL init_mbit128: got %0b, required 0", bus.mbit); end end
      if (n == 256) begin tests++; if (bus.mbit !== 0) begin fails++; $display("FAIL init_mbit256: got %0b, required 0", bus.mbit); end end
      if (n == 384) begin tests++; if (bus.mbit !== 1) begin fails++; $display("FAIL init_mbit384: got %0b, required 1", bus.mbit); end end
      next_cyc();
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL init_ctl: got bad=%0b, required 0", bad); end
  endtask

  task automatic test_ad();
    logic [7:0] ad;
    int k = 0, steps = 0;
    bit rdy_bad = 0, step_bad = 0, mbit_bad = 0, pad_bad = 0;
    ad = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      bus.ad_valid = i[0];
      if (i[0]) begin
        bus.ad_bit = ad[k]; bus.ad_last = (k == 7);
      end else begin
        bus.ad_bit = ~ad[k]; bus.ad_last = (i == 2);
      end
      #1;
      if (i == 0) begin
        tests++;
        if (bus.ad_ready !== 1) begin fails++; $display("FAIL ad_latency: ad_ready got %0b at cycle 1793, required 1", bus.ad_ready); end
      end
      if (bus.ad_ready !== 1 || bus.pt_ready !== 0) rdy_bad = 1;
      if (bus.step_en !== bus.ad_valid || bus.ca !== 1 || bus.cb !== 1) step_bad = 1;
      if (bus.step_en === 1) steps++;
      if (i[0] && bus.mbit !== ad[k]) mbit_bad = 1;
      if (i[0]) k++;
      next_cyc();
    end
    bus.ad_valid = 0; bus.ad_last = 0;
    tests++; if (steps !== 8) begin fails++; $display("FAIL ad_steps: got %0d, required 8", steps); end
    tests++; if (rdy_bad !== 0) begin fails++; $display("FAIL ad_ready: got bad=%0b, required 0", rdy_bad); end
    tests++; if (step_bad !== 0) begin fails++; $display("FAIL ad_step: got bad=%0b, required 0", step_bad); end
    tests++; if (mbit_bad !== 0) begin fails++; $display("FAIL ad_mbit: got bad=%0b, required 0", mbit_bad); end
    for (int n = 0; n < 256; n++) begin
      #1;
      if (n == 0)   begin tests++; if (bus.mbit !== 1) begin fails++; $display("FAIL adpad_mbit0: got %0b, required 1", bus.mbit); end end
      if (n == 127) begin tests++; if (bus.ca !== 1) begin fails++; $display("FAIL adpad_ca127: got %0b, required 1", bus.ca); end end
      if (n == 128) begin tests++; if (bus.ca !== 0) begin fails++; $display("FAIL adpad_ca128: got %0b, required 0", bus.ca); end end
      if (!(bus.step_en === 1 && bus.cb === 1 && bus.ca === (n < 128) && bus.mbit === (n == 0) && bus.ad_ready === 0))
        pad_bad = 1;
      next_cyc();
    end
    tests++; if (pad_bad !== 0) begin fails++; $display("FAIL adpad_ctl: got bad=%0b, required 0", pad_bad); end
  endtask

  task automatic test_enc();
    logic [15:0] pt;
    int k = 0, cyc = 0;
    bit pend = 0, enc_bad = 0, pad_bad = 0;
    pt = 16'hC3A6;
    exp_q.delete();
    while (k < 16 && cyc < 40) begin
      tests++;
      if (bus.ct_valid !== pend) begin
        fails++; $display("FAIL enc ct_valid: got %0b at cyc %0d, required %0b", bus.ct_valid, cyc, pend);
      end else if (pend) begin
        bit e;
        e = exp_q.pop_front();
        tests++;
        if (bus.ct_bit !== e) begin fails++; $display("FAIL enc ct_bit: got %0b at cyc %0d, required %0b", bus.ct_bit, cyc, e); end
      end
      bus.ks_bit = (cyc % 2 == 0);
      if (cyc == 5) begin
        bus.pt_valid = 0; bus.pt_last = 1; bus.pt_bit = 1;
      end else begin
        bus.pt_valid = 1; bus.pt_bit = pt[k]; bus.pt_last = (k == 15);
      end
      #1;
      if (bus.pt_ready !== 1 || bus.ca !== 1 || bus.cb !== 0 || bus.step_en !== bus.pt_valid ||
          (bus.pt_valid && bus.mbit !== bus.pt_bit)) enc_bad = 1;
      if (bus.pt_valid) begin
        exp_q.push_back(bus.pt_bit ^ bus.ks_bit);
        pend = 1; k++;
      end else pend = 0;
      next_cyc();
      cyc++;
    end
    bus.pt_valid = 0; bus.pt_last = 0; bus.pt_bit = 0;
    tests++;
    if (bus.ct_valid !== 1 || exp_q.size() != 1) begin
      fails++; $display("FAIL enc ct_last_valid: got %0b, required 1", bus.ct_valid);
    end else begin
      bit e;
      e = exp_q.pop_front();
      tests++;
      if (bus.ct_bit !== e) begin fails++; $display("FAIL enc ct_last_bit: got %0b, required %0b", bus.ct_bit, e); end
    end
    tests++; if (enc_bad !== 0) begin fails++; $display("FAIL enc_ctl: got bad=%0b, required 0", enc_bad); end
    for (int n = 0; n < 256; n++) begin
      if (n > 0 && bus.ct_valid !== 0) pad_bad = 1;
      bus.ks_bit = 1'($urandom);
      #1;
      if (!(bus.step_en === 1 && bus.cb === 0 && bus.ca === (n < 128) && bus.mbit === (n == 0) && bus.pt_ready === 0))
        pad_bad = 1;
      next_cyc();
    end
    tests++; if (pad_bad !== 0) begin fails++; $display("FAIL encpad_ctl: got bad=%0b, required 0", pad_bad); end
  endtask

  task automatic test_start_in_fin();
    int steps;
    bit bad = 0;
    run_to_done(0, 1, "fin_start", steps);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.busy !== 0 || bus.done !== 0) bad = 1;
      next_cyc();
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL fin_start idle_after: got bad=%0b, required 0", bad); end
  endtask

  task automatic test_rst_mid();
    int steps;
    bit bad = 0;
    start_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1, 0);
    for (int c = 1; c < 1893; c++) next_cyc();
    rst = 1;
    #1;
    tests++;
    if (!(bus.step_en === 1 && bus.ca === 1 && bus.cb === 1 && bus.mbit === 0 && bus.busy === 1)) begin
      fails++; $display("FAIL rst_pre adpad_n100: got %h, required busy/step/ca/cb set", outs());
    end
    next_cyc();
    tests++;
    if (outs() !== 12'h0) begin fails++; $display("FAIL rst_mid outs: got %h, required 000", outs()); end
`ifdef ACORN_CTRL_STATUS_EN
    tests++;
    if (bus.phase !== 3'd0 || bus.total_steps !== 32'd0) begin
      fails++; $display("FAIL rst_mid status: got phase %0d steps %0d, required 0 0", bus.phase, bus.total_steps);
    end
`endif
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.busy !== 0 || bus.done !== 0 || bus.step_en !== 0) bad = 1;
      next_cyc();
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL rst_mid quiet: got bad=%0b, required 0", bad); end
    start_op('0, '0, 1, 1);
    run_to_done(2304, 0, "rst_restart", steps);
    tests++;
    if (steps !== 3072) begin fails++; $display("FAIL rst_restart step_count: got %0d, required 3072", steps); end
  endtask

  initial begin
    test_reset();
    test_empty_run();
    test_init();
    test_ad();
    test_enc();
    test_start_in_fin();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
